// File: rtl/fb_mem_arbiter.sv
// rtl/fb_mem_arbiter.sv - frame-buffer RAM arbiter between VGA scan-out and CPU/DMA port
// Optional CPU starvation guard enabled by defining FB_ARB_FAIR_EN.
module fb_mem_arbiter #(
  parameter int FB_WORDS = 153600,
  parameter int RD_LAT   = 2,
  parameter int WAIT_MAX = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_vga_req,
  input  logic [17:0] i_vga_addr,
  output logic [31:0] o_vga_rdata,
  output logic        o_vga_rvalid,
  output logic        o_vga_miss,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [17:0] i_cpu_addr,
  input  logic [31:0] i_cpu_wdata,
  output logic        o_cpu_gnt,
  output logic [31:0] o_cpu_rdata,
  output logic        o_cpu_rvalid,
  output logic        o_cpu_err,
  output logic [17:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic        o_mem_we,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_VGA, S_CPU} state_t;
  typedef enum logic [1:0] {T_NONE, T_VGA, T_CPU, T_CPU_ERR} tag_t;

  localparam logic [31:0] FB_LIMIT = FB_WORDS;

  state_t      state;
  tag_t        push_tag;
  logic        push_miss;
  logic        forced;
  logic        cpu_oor;
  logic [17:0] last_addr;
  logic [2:0]  pipe [RD_LAT];
  tag_t        out_tag;
  logic        out_miss;

  assign cpu_oor = {14'd0, i_cpu_addr} >= FB_LIMIT;

`ifdef FB_ARB_FAIR_EN
  localparam int WW = $clog2(WAIT_MAX + 1);
  localparam logic [WW-1:0] WAIT_LIM = WW'(WAIT_MAX);
  logic [WW-1:0] wait_cnt;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                       wait_cnt <= '0;
    else if (!i_cpu_req || o_cpu_gnt) wait_cnt <= '0;
    else if (wait_cnt != WAIT_LIM)    wait_cnt <= wait_cnt + 1'b1;
  end

  // Only force while the CPU still asks, so a dropped request never costs a VGA pixel.
  assign forced = i_cpu_req && (wait_cnt == WAIT_LIM);
`else
  assign forced = 1'b0;
`endif

  // Per-cycle owner; reset holds the slot idle so nothing reaches the RAM.
  always_comb begin
    state = S_IDLE;
    if (!i_rst)                      state = S_IDLE;
    else if (i_vga_req && !forced)   state = S_VGA;
    else if (i_cpu_req)              state = S_CPU;
  end

  always_comb begin
    o_cpu_gnt   = 1'b0;
    o_cpu_err   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = last_addr;
    o_mem_wdata = i_cpu_wdata;
    push_tag    = T_NONE;
    push_miss   = 1'b0;
    case (state)
      S_VGA: begin
        o_mem_addr = i_vga_addr;
        push_tag   = T_VGA;
      end
      S_CPU: begin
        o_cpu_gnt  = 1'b1;
        o_cpu_err  = cpu_oor;
        o_mem_addr = i_cpu_addr;
        o_mem_we   = i_cpu_we && !cpu_oor;
        if (!i_cpu_we) push_tag = cpu_oor ? T_CPU_ERR : T_CPU;
        push_miss  = i_vga_req;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      last_addr <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      last_addr <= o_mem_addr;
      pipe[0]   <= {push_miss, push_tag};
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign out_tag  = tag_t'(pipe[RD_LAT-1][1:0]);
  assign out_miss = pipe[RD_LAT-1][2];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_vga_rdata  <= '0;
      o_vga_rvalid <= 1'b0;
      o_cpu_rdata  <= '0;
      o_cpu_rvalid <= 1'b0;
    end else begin
      o_vga_rvalid <= (out_tag == T_VGA) || out_miss;
      o_cpu_rvalid <= (out_tag == T_CPU) || (out_tag == T_CPU_ERR);
      if (out_tag == T_VGA)     o_vga_rdata <= i_mem_rdata;
      if (out_tag == T_CPU)     o_cpu_rdata <= i_mem_rdata;
      if (out_tag == T_CPU_ERR) o_cpu_rdata <= '0;
    end
  end

`ifdef FB_ARB_FAIR_EN
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) o_vga_miss <= 1'b0;
    else        o_vga_miss <= out_miss;
  end
`else
  assign o_vga_miss = 1'b0;
`endif

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// tb/tb_fb_mem_arbiter.sv - directed self-checking bench for fb_mem_arbiter
module tb_fb_mem_arbiter;

  logic        i_clk;
  logic        i_rst;
  logic        i_vga_req;
  logic [17:0] i_vga_addr;
  logic [31:0] o_vga_rdata;
  logic        o_vga_rvalid;
  logic        o_vga_miss;
  logic        i_cpu_req;
  logic        i_cpu_we;
  logic [17:0] i_cpu_addr;
  logic [31:0] i_cpu_wdata;
  logic        o_cpu_gnt;
  logic [31:0] o_cpu_rdata;
  logic        o_cpu_rvalid;
  logic        o_cpu_err;
  logic [17:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        o_mem_we;
  logic [31:0] i_mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [1024];
  logic [17:0] rd_a1, rd_a2;

  fb_mem_arbiter #(.FB_WORDS(153600), .RD_LAT(2), .WAIT_MAX(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_vga_req(i_vga_req), .i_vga_addr(i_vga_addr),
    .o_vga_rdata(o_vga_rdata), .o_vga_rvalid(o_vga_rvalid), .o_vga_miss(o_vga_miss),
    .i_cpu_req(i_cpu_req), .i_cpu_we(i_cpu_we), .i_cpu_addr(i_cpu_addr),
    .i_cpu_wdata(i_cpu_wdata), .o_cpu_gnt(o_cpu_gnt), .o_cpu_rdata(o_cpu_rdata),
    .o_cpu_rvalid(o_cpu_rvalid), .o_cpu_err(o_cpu_err),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_we(o_mem_we),
    .i_mem_rdata(i_mem_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // RAM model: 2-cycle read latency, low 10 address bits, word i preloaded with i+0x100.
  initial for (int i = 0; i < 1024; i++) mem[i] = 32'h100 + 32'(i);
  always @(posedge i_clk) begin
    if (o_mem_we) mem[o_mem_addr[9:0]] <= o_mem_wdata;
    rd_a1 <= o_mem_addr;
    rd_a2 <= rd_a1;
  end
  assign i_mem_rdata = mem[rd_a2[9:0]];

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge i_clk);
    n_cmp++;
    if ({o_vga_rvalid, o_vga_miss, o_cpu_gnt, o_cpu_rvalid, o_cpu_err, o_mem_we} !== 6'b0 ||
        o_vga_rdata !== 32'h0 || o_cpu_rdata !== 32'h0 || o_mem_addr !== 18'h0) begin
      n_bad++;
      $display("FAIL reset_initial: flags=%b vga_rdata=%h cpu_rdata=%h mem_addr=%h, expected all 0",
               {o_vga_rvalid, o_vga_miss, o_cpu_gnt, o_cpu_rvalid, o_cpu_err, o_mem_we},
               o_vga_rdata, o_cpu_rdata, o_mem_addr);
    end
    step();
    i_rst = 1'b1;
    i_vga_req = 1'b1; i_vga_addr = 18'd5;
    step();
    i_vga_addr = 18'd6;
    step();
    i_vga_addr = 18'd7; i_cpu_req = 1'b1; i_cpu_we = 1'b1; i_cpu_addr = 18'h33;
    #2 i_rst = 1'b0;
    #1;
    n_cmp++;
    if ({o_vga_rvalid, o_vga_miss, o_cpu_gnt, o_cpu_rvalid, o_cpu_err, o_mem_we} !== 6'b0 ||
        o_mem_addr !== 18'h0) begin
      n_bad++;
      $display("FAIL reset_midstream: flags=%b mem_addr=%h, expected all 0",
               {o_vga_rvalid, o_vga_miss, o_cpu_gnt, o_cpu_rvalid, o_cpu_err, o_mem_we}, o_mem_addr);
    end
    step();
    i_vga_req = 1'b0; i_cpu_req = 1'b0; i_cpu_we = 1'b0;
    i_rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge i_clk);
      n_cmp++;
      if (o_vga_rvalid !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_discard cycle %0d: vga_rvalid=%b, expected 0", c, o_vga_rvalid);
      end
      step();
    end
  endtask

  task automatic test_vga_stream();
    logic exp_v;
    for (int c = 0; c < 8; c++) begin
      i_vga_req  = (c < 4);
      i_vga_addr = 18'(c);
      @(negedge i_clk);
      if (c < 4) begin
        n_cmp++;
        if (o_mem_addr !== 18'(c)) begin
          n_bad++;
          $display("FAIL vga_mem_addr cycle %0d: got %h, expected %h", c, o_mem_addr, 18'(c));
        end
      end
      exp_v = (c >= 3 && c <= 6);
      n_cmp++;
      if (o_vga_rvalid !== exp_v) begin
        n_bad++;
        $display("FAIL vga_rvalid cycle %0d: got %b, expected %b", c, o_vga_rvalid, exp_v);
      end
      if (exp_v) begin
        n_cmp++;
        if (o_vga_rdata !== 32'h100 + 32'(c - 3) || o_vga_miss !== 1'b0) begin
          n_bad++;
          $display("FAIL vga_rdata cycle %0d: got %h miss=%b, expected %h miss=0",
                   c, o_vga_rdata, o_vga_miss, 32'h100 + 32'(c - 3));
        end
      end
      step();
    end
    i_vga_req = 1'b0;
  endtask

  task automatic test_cpu_rw();
    i_cpu_req = 1'b1; i_cpu_we = 1'b1; i_cpu_addr = 18'h10; i_cpu_wdata = 32'hDEADBEEF;
    @(negedge i_clk);
    n_cmp++;
    if (o_cpu_gnt !== 1'b1 || o_mem_we !== 1'b1 || o_mem_addr !== 18'h10 ||
        o_mem_wdata !== 32'hDEADBEEF || o_cpu_err !== 1'b0) begin
      n_bad++;
      $display("FAIL cpu_write: gnt=%b we=%b addr=%h wdata=%h err=%b, expected 1 1 00010 deadbeef 0",
               o_cpu_gnt, o_mem_we, o_mem_addr, o_mem_wdata, o_cpu_err);
    end
    step();
    i_cpu_we = 1'b0;
    @(negedge i_clk);
    n_cmp++;
    if (o_cpu_gnt !== 1'b1 || o_mem_we !== 1'b0) begin
      n_bad++;
      $display("FAIL cpu_read_gnt: gnt=%b we=%b, expected 1 0", o_cpu_gnt, o_mem_we);
    end
    step();
    i_cpu_req = 1'b0;
    for (int c = 2; c < 6; c++) begin
      @(negedge i_clk);
      n_cmp++;
      if (o_cpu_rvalid !== (c == 4)) begin
        n_bad++;
        $display("FAIL cpu_rvalid cycle %0d: got %b, expected %b", c, o_cpu_rvalid, (c == 4));
      end
      if (c == 4) begin
        n_cmp++;
        if (o_cpu_rdata !== 32'hDEADBEEF) begin
          n_bad++;
          $display("FAIL cpu_rdata: got %h, expected deadbeef", o_cpu_rdata);
        end
      end
      step();
    end
  endtask

  task automatic test_contention();
    int n;
`ifdef FB_ARB_FAIR_EN
    n = 4;
`else
    n = 5;
`endif
    for (int c = 0; c < n; c++) begin
      i_vga_req = 1'b1; i_vga_addr = 18'h20 + 18'(c);
      i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = 18'h11;
      @(negedge i_clk);
      n_cmp++;
      if (o_cpu_gnt !== 1'b0 || o_mem_addr !== 18'h20 + 18'(c)) begin
        n_bad++;
        $display("FAIL contention cycle %0d: gnt=%b addr=%h, expected 0 %h",
                 c, o_cpu_gnt, o_mem_addr, 18'h20 + 18'(c));
      end
      step();
    end
    i_vga_req = 1'b0;
    @(negedge i_clk);
    n_cmp++;
    if (o_cpu_gnt !== 1'b1 || o_mem_addr !== 18'h11) begin
      n_bad++;
      $display("FAIL contention_release: gnt=%b addr=%h, expected 1 00011", o_cpu_gnt, o_mem_addr);
    end
    step();
    i_cpu_req = 1'b0;
    for (int d = 1; d < 5; d++) begin
      @(negedge i_clk);
      n_cmp++;
      if (o_cpu_rvalid !== (d == 3) || (d == 3 && o_cpu_rdata !== 32'h111)) begin
        n_bad++;
        $display("FAIL contention_read d=%0d: rvalid=%b rdata=%h, expected %b 00000111",
                 d, o_cpu_rvalid, o_cpu_rdata, (d == 3));
      end
      step();
    end
  endtask

  task automatic test_range();
    i_cpu_req = 1'b1; i_cpu_we = 1'b1; i_cpu_addr = 18'd153600; i_cpu_wdata = 32'h12345678;
    @(negedge i_clk);
    n_cmp++;
    if (o_cpu_gnt !== 1'b1 || o_cpu_err !== 1'b1 || o_mem_we !== 1'b0) begin
      n_bad++;
      $display("FAIL range_write: gnt=%b err=%b we=%b, expected 1 1 0", o_cpu_gnt, o_cpu_err, o_mem_we);
    end
    step();
    i_cpu_we = 1'b0;
    @(negedge i_clk);
    n_cmp++;
    if (o_cpu_gnt !== 1'b1 || o_cpu_err !== 1'b1) begin
      n_bad++;
      $display("FAIL range_read: gnt=%b err=%b, expected 1 1", o_cpu_gnt, o_cpu_err);
    end
    step();
    i_cpu_addr = 18'd153599;
    @(negedge i_clk);
    n_cmp++;
    if (o_cpu_gnt !== 1'b1 || o_cpu_err !== 1'b0) begin
      n_bad++;
      $display("FAIL range_last_word: gnt=%b err=%b, expected 1 0", o_cpu_gnt, o_cpu_err);
    end
    step();
    i_cpu_req = 1'b0;
    for (int c = 3; c < 7; c++) begin
      @(negedge i_clk);
      n_cmp++;
      if (o_cpu_rvalid !== (c == 4 || c == 5)) begin
        n_bad++;
        $display("FAIL range_rvalid cycle %0d: got %b, expected %b", c, o_cpu_rvalid, (c == 4 || c == 5));
      end
      if (c == 4) begin
        n_cmp++;
        if (o_cpu_rdata !== 32'h0) begin
          n_bad++;
          $display("FAIL range_err_rdata: got %h, expected 00000000", o_cpu_rdata);
        end
      end
      if (c == 5) begin
        n_cmp++;
        if (o_cpu_rdata !== 32'h4FF) begin
          n_bad++;
          $display("FAIL range_last_rdata: got %h, expected 000004ff", o_cpu_rdata);
        end
      end
      step();
    end
    n_cmp++;
    if (mem[0] !== 32'h100) begin
      n_bad++;
      $display("FAIL range_ram_unchanged: got %h, expected 00000100", mem[0]);
    end
  endtask

  task automatic test_fair();
`ifdef FB_ARB_FAIR_EN
    logic granted;
    granted = 1'b0;
    for (int c = 0; c < 10; c++) begin
      i_vga_req = 1'b1; i_vga_addr = 18'h40 + 18'(c);
      i_cpu_req = !granted; i_cpu_we = 1'b0; i_cpu_addr = 18'h10;
      @(negedge i_clk);
      n_cmp++;
      if (o_cpu_gnt !== (c == 4)) begin
        n_bad++;
        $display("FAIL fair_gnt cycle %0d: got %b, expected %b", c, o_cpu_gnt, (c == 4));
      end
      if (o_cpu_gnt) granted = 1'b1;
      if (c >= 3) begin
        n_cmp++;
        if (o_vga_rvalid !== 1'b1 || o_vga_miss !== (c == 7)) begin
          n_bad++;
          $display("FAIL fair_vga cycle %0d: rvalid=%b miss=%b, expected 1 %b",
                   c, o_vga_rvalid, o_vga_miss, (c == 7));
        end
      end
      if (c == 7) begin
        n_cmp++;
        if (o_vga_rdata !== 32'h143 || o_cpu_rvalid !== 1'b1 || o_cpu_rdata !== 32'hDEADBEEF) begin
          n_bad++;
          $display("FAIL fair_miss_data: vga_rdata=%h cpu_rvalid=%b cpu_rdata=%h, expected 00000143 1 deadbeef",
                   o_vga_rdata, o_cpu_rvalid, o_cpu_rdata);
        end
      end
      if (c == 8) begin
        n_cmp++;
        if (o_vga_rdata !== 32'h145) begin
          n_bad++;
          $display("FAIL fair_resume: vga_rdata=%h, expected 00000145", o_vga_rdata);
        end
      end
      step();
    end
`else
    int gnts;
    int misses;
    gnts = 0;
    misses = 0;
    for (int c = 0; c < 1000; c++) begin
      i_vga_req = 1'b1; i_vga_addr = 18'(c & 1023);
      i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = 18'h10;
      @(negedge i_clk);
      if (o_cpu_gnt === 1'b1) gnts++;
      if (o_vga_miss !== 1'b0) misses++;
      step();
    end
    n_cmp++;
    if (gnts != 0) begin
      n_bad++;
      $display("FAIL strict_starve: gnt cycles=%0d, expected 0", gnts);
    end
    n_cmp++;
    if (misses != 0) begin
      n_bad++;
      $display("FAIL strict_no_miss: miss cycles=%0d, expected 0", misses);
    end
`endif
    i_vga_req = 1'b0; i_cpu_req = 1'b0;
    for (int c = 0; c < 4; c++) step();
  endtask

  initial begin
    i_rst = 1'b0;
    i_vga_req = 1'b0; i_vga_addr = '0;
    i_cpu_req = 1'b0; i_cpu_we = 1'b0; i_cpu_addr = '0; i_cpu_wdata = '0;
    test_reset();
    test_vga_stream();
    test_cpu_rw();
    test_contention();
    test_range();
    test_fair();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
